// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single data-memory port; one transaction outstanding.
// Define MEM_ARB_RR_EN for round-robin on conflict; default is fixed LSU priority.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters
// HOLD  | grant locked to owner, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_resp_valid
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   winner;
    logic   grant_lsu;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // On conflict, hand the port to whoever did not get the previous handshake.
    always_comb begin
        if (ifu_req_valid && lsu_req_valid) begin
            winner = ~last_q;
        end else begin
            winner = lsu_req_valid;
        end
    end
`else
    always_comb begin
        winner = lsu_req_valid;
    end
`endif

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
`ifdef MEM_ARB_RR_EN
        last_d         = last_q;
`endif
        grant_lsu      = OWN_IFU;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_req_valid  = 1'b0;
        mem_wen        = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (ifu_req_valid || lsu_req_valid) begin
                        mem_req_valid = 1'b1;
                        grant_lsu     = winner;
                        owner_d       = winner;
                        if (mem_req_ready) begin
                            state_d = ST_WAIT;
`ifdef MEM_ARB_RR_EN
                            last_d  = winner;
`endif
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    mem_req_valid = 1'b1;
                    grant_lsu     = owner_q;
                    if (mem_req_ready) begin
                        state_d = ST_WAIT;
`ifdef MEM_ARB_RR_EN
                        last_d  = owner_q;
`endif
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        ifu_resp_valid = (owner_q == OWN_IFU);
                        lsu_resp_valid = (owner_q == OWN_LSU);
                        state_d        = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (mem_req_valid) begin
                ifu_req_ready = mem_req_ready && (grant_lsu == OWN_IFU);
                lsu_req_ready = mem_req_ready && (grant_lsu == OWN_LSU);
                if (grant_lsu == OWN_LSU) begin
                    mem_wen   = lsu_wen;
                    mem_addr  = lsu_addr;
                    mem_wdata = lsu_wdata;
                    mem_wmask = lsu_wmask;
                end else begin
                    mem_addr  = ifu_addr;
                end
            end
        end
    end

    // Read data is a pass-through; only the owner's resp_valid qualifies it.
    assign ifu_rdata = rst ? '0 : mem_rdata;
    assign lsu_rdata = rst ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWN_LSU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (pending grant / outstanding owner / last winner).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic          lsu_wen = 1'b0;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_lock = requester holding an unaccepted grant, m_out = owner of the
    // accepted transaction, m_last = last handshake winner (-1 means none; 0 IFU, 1 LSU).
    int m_lock = -1;
    int m_out  = -1;
    int m_last = 1;
    bit ifu_acc = 1'b0;
    bit lsu_acc = 1'b0;
    bit mem_acc = 1'b0;

    always @(negedge clk) begin
        int            cand;
        logic          e_mv, e_ir, e_lr, e_irv, e_lrv, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [MW-1:0] e_wmask;
        cand = -1;
        e_mv = 1'b0; e_ir = 1'b0; e_lr = 1'b0; e_irv = 1'b0; e_lrv = 1'b0;
        e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_wmask = '0;
        if (rst) begin
            chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
            chk1("rst_ifu_req_ready", ifu_req_ready, 1'b0);
            chk1("rst_lsu_req_ready", lsu_req_ready, 1'b0);
            chk1("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
            chk1("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
            chk1("rst_mem_wen", mem_wen, 1'b0);
            chk32("rst_mem_addr", mem_addr, 32'h0);
            chk32("rst_mem_wdata", mem_wdata, 32'h0);
            chk32("rst_mem_wmask", 32'(mem_wmask), 32'h0);
            chk32("rst_ifu_rdata", ifu_rdata, 32'h0);
            chk32("rst_lsu_rdata", lsu_rdata, 32'h0);
            m_lock = -1;
            m_out  = -1;
            m_last = 1;
        end else begin
            if (m_out >= 0) begin
                if (mem_resp_valid) begin
                    e_irv = (m_out == 0);
                    e_lrv = (m_out == 1);
                end
            end else if (m_lock >= 0) begin
                cand = m_lock;
            end else if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
                cand = (m_last == 1) ? 0 : 1;
`else
                cand = 1;
`endif
            end else if (lsu_req_valid) begin
                cand = 1;
            end else if (ifu_req_valid) begin
                cand = 0;
            end

            if (cand >= 0) begin
                e_mv = 1'b1;
                e_ir = mem_req_ready && (cand == 0);
                e_lr = mem_req_ready && (cand == 1);
                if (cand == 1) begin
                    e_wen = lsu_wen; e_addr = lsu_addr; e_wdata = lsu_wdata; e_wmask = lsu_wmask;
                end else begin
                    e_addr = ifu_addr;
                end
            end

            chk1("mem_req_valid", mem_req_valid, e_mv);
            chk1("ifu_req_ready", ifu_req_ready, e_ir);
            chk1("lsu_req_ready", lsu_req_ready, e_lr);
            chk1("ifu_resp_valid", ifu_resp_valid, e_irv);
            chk1("lsu_resp_valid", lsu_resp_valid, e_lrv);
            if (e_mv) begin
                chk1("mem_wen", mem_wen, e_wen);
                chk32("mem_addr", mem_addr, e_addr);
                chk32("mem_wdata", mem_wdata, e_wdata);
                chk32("mem_wmask", 32'(mem_wmask), 32'(e_wmask));
            end
            if (e_irv) chk32("ifu_rdata", ifu_rdata, mem_rdata);
            if (e_lrv) chk32("lsu_rdata", lsu_rdata, mem_rdata);

            if (m_out >= 0) begin
                if (mem_resp_valid) m_out = -1;
            end else if (cand >= 0) begin
                if (mem_req_ready) begin
                    m_out  = cand;
                    m_lock = -1;
                    m_last = cand;
                end else begin
                    m_lock = cand;
                end
            end
        end
        ifu_acc = ifu_req_valid && ifu_req_ready;
        lsu_acc = lsu_req_valid && lsu_req_ready;
        mem_acc = mem_req_valid && mem_req_ready;
    end

    // Both requesters present at once: first_lsu says who must win.
    task automatic conflict(input bit first_lsu);
        logic [31:0] a_first, a_second;
        a_first  = first_lsu ? 32'h80001000 : 32'h80000004;
        a_second = first_lsu ? 32'h80000004 : 32'h80001000;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000004;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h80001000;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk32("conf_first_addr", mem_addr, a_first);
        chk1("conf_first_lsu_ready", lsu_req_ready, first_lsu);
        chk1("conf_first_ifu_ready", ifu_req_ready, !first_lsu);
        @(posedge clk); #1;
        lsu_req_valid = !first_lsu; ifu_req_valid = first_lsu;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h11112222;
        @(negedge clk);
        chk1("conf_first_lsu_resp", lsu_resp_valid, first_lsu);
        chk1("conf_first_ifu_resp", ifu_resp_valid, !first_lsu);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk32("conf_second_addr", mem_addr, a_second);
        chk1("conf_second_lsu_ready", lsu_req_ready, !first_lsu);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        @(negedge clk);
        chk1("conf_second_lsu_resp", lsu_resp_valid, !first_lsu);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        bit first_lsu;
        int pend;
`ifdef MEM_ARB_RR_EN
        first_lsu = 1'b0;
`else
        first_lsu = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single IFU fetch
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000000; mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("fetch_ifu_ready", ifu_req_ready, 1'b1);
        chk32("fetch_addr", mem_addr, 32'h80000000);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
        @(negedge clk);
        chk1("fetch_wait_no_req", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h00000413;
        @(negedge clk);
        chk1("fetch_resp_valid", ifu_resp_valid, 1'b1);
        chk32("fetch_rdata", ifu_rdata, 32'h00000413);
        chk1("fetch_lsu_resp", lsu_resp_valid, 1'b0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        conflict(first_lsu);
        conflict(first_lsu);

        // HOLD lock, then a store
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000008; mem_req_ready = 1'b0;
        @(negedge clk);
        chk32("hold_addr_c1", mem_addr, 32'h80000008);
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h80002000;
        lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
        @(negedge clk);
        chk32("hold_addr_c2", mem_addr, 32'h80000008);
        chk1("hold_wen_c2", mem_wen, 1'b0);
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("hold_ifu_ready", ifu_req_ready, 1'b1);
        chk1("hold_lsu_ready", lsu_req_ready, 1'b0);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        @(negedge clk);
        chk1("hold_ifu_resp", ifu_resp_valid, 1'b1);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("store_wen", mem_wen, 1'b1);
        chk32("store_addr", mem_addr, 32'h80002000);
        chk32("store_wdata", mem_wdata, 32'hDEADBEEF);
        chk32("store_wmask", 32'(mem_wmask), 32'h0000000F);
        chk1("store_ready", lsu_req_ready, 1'b1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        chk1("store_ack", lsu_resp_valid, 1'b1);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk1("store_ack_one_cycle", lsu_resp_valid, 1'b0);

        // reset while waiting for a response
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000000C; mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("rw_accept", ifu_req_ready, 1'b1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000010; mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("rw_late_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("rw_late_lsu_resp", lsu_resp_valid, 1'b0);
        chk1("rw_new_accept", ifu_req_ready, 1'b1);
        chk32("rw_new_addr", mem_addr, 32'h80000010);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        chk1("rw_new_resp", ifu_resp_valid, 1'b1);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;

        // randomized traffic, spurious responses and occasional resets
        pend = -1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            if (ifu_acc) ifu_req_valid = 1'b0;
            if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
                ifu_req_valid = 1'b1;
                ifu_addr      = $urandom;
            end
            if (lsu_acc) lsu_req_valid = 1'b0;
            if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
                lsu_req_valid = 1'b1;
                lsu_wen       = 1'($urandom_range(0, 1));
                lsu_addr      = $urandom;
                lsu_wdata     = $urandom;
                lsu_wmask     = 4'($urandom_range(0, 15));
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rdata     = $urandom;
            if (mem_acc) pend = $urandom_range(0, 3);
            mem_resp_valid = 1'b0;
            if (pend == 0) begin
                mem_resp_valid = 1'b1;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_resp_valid = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
